// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of the shared data memory.
// Port 0 is the CPU MEM stage, port 1 the DMA/debug loader; accesses run IDLE -> ACCESS -> RESP.
module dm_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CW           = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic [2:0]    cpu_type,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   input  logic [2:0]    dma_type,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic          dm_we,
   output logic [2:0]    dm_type,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_din,
   input  logic [DW-1:0] dm_dout,
   output logic          busy
);

   localparam int NP = 2;
   localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic          we_reg;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] wdata_reg;
   logic [2:0]    type_reg;
   logic          id_reg;
   logic [DW-1:0] rdata_reg;
   logic [CW-1:0] starve_cnt_reg, starve_cnt_next;

   // Per-port views of the request interfaces, indexed by port id.
   logic [NP-1:0] req_vec;
   logic [NP-1:0] we_vec;
   logic [NP-1:0] ack_vec;
   logic [AW-1:0] addr_vec  [NP];
   logic [DW-1:0] wdata_vec [NP];
   logic [2:0]    type_vec  [NP];

   assign req_vec      = {dma_req, cpu_req};
   assign we_vec       = {dma_we, cpu_we};
   assign addr_vec[0]  = cpu_addr;
   assign addr_vec[1]  = dma_addr;
   assign wdata_vec[0] = cpu_wdata;
   assign wdata_vec[1] = dma_wdata;
   assign type_vec[0]  = cpu_type;
   assign type_vec[1]  = dma_type;

   logic any_req;
   logic grant_id;
   logic load_cmd;
   logic load_rdata;

   assign any_req = |req_vec;

   // CPU has fixed priority unless DMA has waited through STARVE_LIMIT CPU grants.
   assign grant_id = req_vec[1] & (~req_vec[0] | (starve_cnt_reg >= STARVE_MAX));

   always_comb begin
      state_next = state_reg;
      load_cmd   = 1'b0;
      load_rdata = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (any_req) begin
               load_cmd   = 1'b1;
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            load_rdata = ~we_reg;
            state_next = ST_RESP;
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (load_cmd) begin
         if (grant_id || !dma_req) begin
            starve_cnt_next = '0;
         end else if (starve_cnt_reg < STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         type_reg       <= 3'b000;
         id_reg         <= 1'b0;
         rdata_reg      <= '0;
         starve_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
         if (load_cmd) begin
            we_reg    <= we_vec[grant_id];
            addr_reg  <= addr_vec[grant_id];
            wdata_reg <= wdata_vec[grant_id];
            type_reg  <= type_vec[grant_id];
            id_reg    <= grant_id;
         end
         if (load_rdata) begin
            rdata_reg <= dm_dout;
         end
      end
   end

   // Ack goes to whichever port owns the command currently in RESP.
   for (genvar gi = 0; gi < NP; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ST_RESP) && (id_reg == 1'(gi)) && !rst;
   end

   assign cpu_ack   = ack_vec[0];
   assign dma_ack   = ack_vec[1];
   assign cpu_rdata = rdata_reg;
   assign dma_rdata = rdata_reg;
   assign cpu_stall = cpu_req & ~cpu_ack;

   // Write strobe is suppressed during reset so an interrupted access never commits.
   assign dm_we   = (state_reg == ST_ACCESS) & we_reg & ~rst;
   assign dm_type = type_reg;
   assign dm_addr = addr_reg;
   assign dm_din  = wdata_reg;
   assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a small word memory standing in for dm.
module tb_dm_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr, dm_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, dm_din, dm_dout;
   logic [2:0]    cpu_type, dma_type, dm_type;
   logic          cpu_ack, cpu_stall, dma_ack, dm_we, busy;

   dm_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .CW(3)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_type(cpu_type), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_type(dma_type), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dm_we(dm_we), .dm_type(dm_type), .dm_addr(dm_addr), .dm_din(dm_din),
      .dm_dout(dm_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = 8'd0;
   logic [31:0] pre_data = 32'd0;
   int          wr_cnt = 0;

   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_data;
      else if (dm_we) mem[dm_addr[9:2]] <= dm_din;
   end
   always @(posedge clk) if (dm_we) wr_cnt <= wr_cnt + 1;
   assign dm_dout = mem[dm_addr[9:2]];

   typedef struct {
      bit          port;
      bit          chk;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      pre_en = 1'b1; pre_idx = addr[9:2]; pre_data = data;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] typ);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_type = typ;
   endtask

   task automatic dma_issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] typ);
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; dma_type = typ;
   endtask

   // Steps until an ack appears; lat=0 means the bound expired.
   task automatic wait_ack(output bit port, output logic [31:0] data, output int lat,
                           output bit both);
      port = 1'b0; data = '0; lat = 0; both = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (cpu_ack && dma_ack) both = 1'b1;
         if (cpu_ack || dma_ack) begin
            port = dma_ack; data = cpu_rdata; lat = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_type = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_type = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({cpu_ack, dma_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {cpu_ack, dma_ack}); end
      checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", cpu_rdata); end
      checks++; if (dm_we !== 1'b0 || dm_addr !== 32'h0 || dm_type !== 3'b000) begin
         failures++; $display("FAIL reset_dm got we=%b addr=%h type=%b exp 0/0/0", dm_we, dm_addr, dm_type);
      end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", cpu_stall); end
      $display("test_reset done");
   endtask

   task automatic test_cpu_read();
      exp_t e;
      preload(32'h10, 32'hDEADBEEF);
      sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
      cpu_issue(1'b0, 32'h10, 32'h0, 3'b010);
      #1;
      checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL cpu_read_stall_c0 got=%b exp=1", cpu_stall); end
      tick();
      checks++; if (dm_we !== 1'b0 || busy !== 1'b1 || dm_addr !== 32'h10) begin
         failures++; $display("FAIL cpu_read_c1 got we=%b busy=%b addr=%h exp 0/1/10", dm_we, busy, dm_addr);
      end
      checks++; if (cpu_stall !== 1'b1 || cpu_ack !== 1'b0) begin
         failures++; $display("FAIL cpu_read_c1_hs got stall=%b ack=%b exp 1/0", cpu_stall, cpu_ack);
      end
      tick();
      e = sb.pop_front();
      checks++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || cpu_stall !== 1'b0) begin
         failures++; $display("FAIL cpu_read_c2_hs got ack=%b dack=%b stall=%b exp 1/0/0", cpu_ack, dma_ack, cpu_stall);
      end
      checks++; if (cpu_rdata !== e.data) begin failures++; $display("FAIL cpu_read_data got=%h exp=%h", cpu_rdata, e.data); end
      cpu_req = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cpu_read_idle got busy=%b exp=0", busy); end
      $display("test_cpu_read: addr=10 data=%h", cpu_rdata);
   endtask

   task automatic test_dma_write_cpu_read();
      exp_t e; bit port, both; logic [31:0] d; int lat, wr0;
      wr0 = wr_cnt;
      sb.push_back('{port: 1'b1, chk: 1'b0, data: 32'h0});
      dma_issue(1'b1, 32'h20, 32'h12345678, 3'b010);
      wait_ack(port, d, lat, both);
      e = sb.pop_front();
      checks++; if (lat !== 2 || port !== e.port || both) begin
         failures++; $display("FAIL dma_write_ack got lat=%0d port=%b both=%b exp 2/%b/0", lat, port, both, e.port);
      end
      dma_req = 1'b0;
      tick();
      checks++; if (wr_cnt - wr0 !== 1 || mem[8] !== 32'h12345678) begin
         failures++; $display("FAIL dma_write_commit got writes=%0d mem=%h exp 1/12345678", wr_cnt - wr0, mem[8]);
      end
      sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'h12345678});
      cpu_issue(1'b0, 32'h20, 32'h0, 3'b010);
      wait_ack(port, d, lat, both);
      e = sb.pop_front();
      checks++; if (lat !== 2 || port !== e.port || d !== e.data || both) begin
         failures++; $display("FAIL cpu_readback got lat=%0d port=%b data=%h exp 2/%b/%h", lat, port, d, e.port, e.data);
      end
      cpu_req = 1'b0;
      tick();
      $display("test_dma_write_cpu_read: dma wrote 20, cpu read %h", d);
   endtask

   task automatic test_starvation();
      exp_t e; bit port, both; logic [31:0] d; int lat;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) sb.push_back('{port: 1'b1, chk: 1'b1, data: 32'h12345678});
         else sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
      end
      cpu_issue(1'b0, 32'h10, 32'h0, 3'b010);
      dma_issue(1'b0, 32'h20, 32'h0, 3'b010);
      for (int k = 0; k < 10; k++) begin
         wait_ack(port, d, lat, both);
         e = sb.pop_front();
         checks++; if (lat == 0 || port !== e.port || d !== e.data || both) begin
            failures++; $display("FAIL starve_grant%0d got lat=%0d port=%b data=%h both=%b exp port=%b data=%h", k, lat, port, d, both, e.port, e.data);
         end
         $display("starve grant %0d: port=%0d data=%h", k, port, d);
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bit port, both; logic [31:0] d; int lat, t0, wr0;
      wr0 = wr_cnt;
      sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'hDEADBEEF});
      sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'h12345678});
      cpu_issue(1'b0, 32'h10, 32'h0, 3'b010);
      wait_ack(port, d, lat, both);
      begin
         exp_t e = sb.pop_front();
         checks++; if (lat !== 2 || d !== e.data) begin failures++; $display("FAIL b2b_first got lat=%0d data=%h exp 2/%h", lat, d, e.data); end
      end
      t0 = cyc;
      cpu_addr = 32'h20;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b exp=0", busy); end
      tick();
      checks++; if (dm_addr !== 32'h20) begin failures++; $display("FAIL b2b_access_addr got=%h exp=20", dm_addr); end
      tick();
      begin
         exp_t e = sb.pop_front();
         checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== e.data || cyc - t0 !== 3) begin
            failures++; $display("FAIL b2b_second got ack=%b data=%h period=%0d exp 1/%h/3", cpu_ack, cpu_rdata, cyc - t0, e.data);
         end
      end
      cpu_req = 1'b0;
      tick(); tick();
      checks++; if (busy !== 1'b0 || wr_cnt !== wr0) begin
         failures++; $display("FAIL b2b_no_extra got busy=%b writes=%0d exp 0/0", busy, wr_cnt - wr0);
      end
      $display("test_back_to_back: period=3 second data=12345678");
   endtask

   task automatic test_reset_mid_access();
      int wr0;
      preload(32'h30, 32'hAAAA5555);
      wr0 = wr_cnt;
      dma_issue(1'b1, 32'h30, 32'h11112222, 3'b010);
      tick();
      checks++; if (dm_we !== 1'b1) begin failures++; $display("FAIL rst_mid_pre_we got=%b exp=1", dm_we); end
      rst = 1'b1; dma_req = 1'b0;
      #1;
      checks++; if (dm_we !== 1'b0) begin failures++; $display("FAIL rst_mid_we got=%b exp=0", dm_we); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0 || cpu_rdata !== 32'h0) begin
         failures++; $display("FAIL rst_mid_state got busy=%b ack=%b%b rdata=%h exp 0/00/0", busy, cpu_ack, dma_ack, cpu_rdata);
      end
      tick();
      checks++; if (mem[12] !== 32'hAAAA5555 || wr_cnt !== wr0) begin
         failures++; $display("FAIL rst_mid_mem got=%h writes=%0d exp AAAA5555/0", mem[12], wr_cnt - wr0);
      end
      $display("test_reset_mid_access: mem30=%h", mem[12]);
   endtask

   task automatic test_type_passthrough();
      exp_t e;
      sb.push_back('{port: 1'b0, chk: 1'b1, data: 32'hAAAA5555});
      dma_type = 3'b101;
      cpu_issue(1'b0, 32'h30, 32'h0, 3'b011);
      tick();
      checks++; if (dm_type !== 3'b011) begin failures++; $display("FAIL type_cpu got=%b exp=011", dm_type); end
      tick();
      e = sb.pop_front();
      checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== e.data) begin
         failures++; $display("FAIL type_cpu_ack got ack=%b data=%h exp 1/%h", cpu_ack, cpu_rdata, e.data);
      end
      cpu_req = 1'b0;
      tick();
      sb.push_back('{port: 1'b1, chk: 1'b1, data: 32'h12345678});
      dma_issue(1'b0, 32'h20, 32'h0, 3'b101);
      tick();
      checks++; if (dm_type !== 3'b101) begin failures++; $display("FAIL type_dma got=%b exp=101", dm_type); end
      tick();
      e = sb.pop_front();
      checks++; if (dma_ack !== 1'b1 || cpu_ack !== 1'b0 || dma_rdata !== e.data) begin
         failures++; $display("FAIL type_dma_ack got ack=%b cack=%b data=%h exp 1/0/%h", dma_ack, cpu_ack, dma_rdata, e.data);
      end
      dma_req = 1'b0;
      tick();
      $display("test_type_passthrough: cpu type 011, dma type 101");
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_dma_write_cpu_read();
      test_starvation();
      test_back_to_back();
      test_reset_mid_access();
      test_type_passthrough();
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=timeout exp=finish");
      $fatal(1, "timeout");
   end
endmodule
